// File: rtl/nibble_serial_adder.sv
// Serial multi-word adder: one 4-bit ripple nibble adder reused over WIDTH/4 cycles,
// LSB nibble first, with the inter-nibble carry held in a flop.
module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int unsigned NIBBLES = WIDTH / 4;
   localparam int unsigned CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADD  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic [4:0] nib_sum;
   logic       accept;
   logic       last_nib;

   // Shared nibble adder: low nibbles of the operand shift registers plus held carry.
   assign nib_sum  = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};
   assign accept   = in_valid & in_ready;
   assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ADD;
         S_ADD:   if (last_nib) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; in_ready is also gated by reset so it reads 0 during reset
   always_comb begin
      in_ready  = (state_q == S_IDLE) & rst_n;
      out_valid = (state_q == S_DONE);
      busy      = (state_q != S_IDLE);
   end

   // Datapath next values
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         S_ADD: begin
            a_sh_d  = a_sh_q >> 4;
            b_sh_d  = b_sh_q >> 4;
            sum_d   = {nib_sum[3:0], sum_q[WIDTH-1:4]};
            carry_d = nib_sum[4];
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_nib) cout_d = nib_sum[4];
         end
         default: begin
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): each scenario task drives
// stimulus and compares against hand-computed results inline.
module tb_nibble_serial_adder;

   localparam int unsigned WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int n_cmp = 0;
   int n_bad = 0;

   nibble_serial_adder #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; drive and sample 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run one operation; lat counts edges from the accept edge (counted as 1) to out_valid rise.
   task automatic run_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi, input logic ci,
                         output logic [WIDTH-1:0] s, output logic c, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         tick();
         w++;
      end
      a = ai; b = bi; cin = ci; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      s = sum;
      c = cout;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick();
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
      n_cmp++; if ({cout, sum} !== 17'h0) begin n_bad++; $display("FAIL reset_sum got %0b_%h want 0_0000", cout, sum); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_in_ready got %0b want 1", in_ready); end
   endtask

   task automatic test_simple();
      logic [WIDTH-1:0] s; logic c; int lat;
      run_op(16'h0001, 16'h0002, 1'b0, s, c, lat);
      n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL simple_latency got %0d want 5", lat); end
      n_cmp++; if ({c, s} !== {1'b0, 16'h0003}) begin n_bad++; $display("FAIL simple_sum got %0b_%h want 0_0003", c, s); end
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_bad++; $display("FAIL simple_handshake got ov=%0b ir=%0b want ov=0 ir=1", out_valid, in_ready); end
   endtask

   task automatic test_ripple();
      logic [WIDTH-1:0] s; logic c; int lat;
      run_op(16'hFFFF, 16'h0001, 1'b0, s, c, lat);
      n_cmp++; if ({c, s} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL ripple_ffff got %0b_%h want 1_0000", c, s); end
      run_op(16'hAAAA, 16'h5555, 1'b1, s, c, lat);
      n_cmp++; if ({c, s} !== {1'b1, 16'h0000}) begin n_bad++; $display("FAIL ripple_aaaa got %0b_%h want 1_0000", c, s); end
      run_op(16'h1234, 16'h4321, 1'b0, s, c, lat);
      n_cmp++; if ({c, s} !== {1'b0, 16'h5555}) begin n_bad++; $display("FAIL plain_1234 got %0b_%h want 0_5555", c, s); end
      run_op(16'h0FF8, 16'h0008, 1'b1, s, c, lat);
      n_cmp++; if ({c, s} !== {1'b0, 16'h1001}) begin n_bad++; $display("FAIL mid_ripple got %0b_%h want 0_1001", c, s); end
   endtask

   task automatic test_backpressure();
      int w;
      a = 16'h1234; b = 16'h4321; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 20) begin tick(); w++; end
      for (int i = 0; i < 6; i++) begin
         in_valid = i[0];
         a = 16'h1111 * 16'(i + 1); b = 16'h0F0F; cin = ~i[0];
         tick();
         n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL bp_flags_%0d got ov=%0b ir=%0b busy=%0b want 1 0 1", i, out_valid, in_ready, busy); end
         n_cmp++; if ({cout, sum} !== {1'b0, 16'h5556}) begin
            n_bad++; $display("FAIL bp_hold_%0d got %0b_%h want 0_5556", i, cout, sum); end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
         n_bad++; $display("FAIL bp_release got ov=%0b ir=%0b busy=%0b want 0 1 0", out_valid, in_ready, busy); end
      n_cmp++; if ({cout, sum} !== {1'b0, 16'h5556}) begin
         n_bad++; $display("FAIL bp_after_hs got %0b_%h want 0_5556", cout, sum); end
   endtask

   task automatic test_reset_mid_add();
      logic [WIDTH-1:0] s; logic c; int lat;
      a = 16'h7777; b = 16'h8888; cin = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL midrst_flags got busy=%0b ov=%0b ir=%0b want 0 0 0", busy, out_valid, in_ready); end
      n_cmp++; if ({cout, sum} !== 17'h0) begin n_bad++; $display("FAIL midrst_sum got %0b_%h want 0_0000", cout, sum); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
      run_op(16'h00FF, 16'h0001, 1'b0, s, c, lat);
      n_cmp++; if ({c, s} !== {1'b0, 16'h0100}) begin n_bad++; $display("FAIL midrst_next got %0b_%h want 0_0100", c, s); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH:0] exp_q[$];
      logic [WIDTH:0] exp;
      int n_acc, n_res, acc_cyc, hs_cyc;
      n_acc = 0; n_res = 0; acc_cyc = -1; hs_cyc = -1;
      a = 16'h8000; b = 16'h8000; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      for (int cyc = 0; cyc < 40 && n_res < 2; cyc++) begin
         if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {16'h0000, cin});
            n_acc++;
            if (n_acc == 2) acc_cyc = cyc;
         end
         if (out_valid && out_ready) begin
            exp = exp_q.pop_front();
            n_cmp++; if ({cout, sum} !== exp) begin
               n_bad++; $display("FAIL b2b_result_%0d got %0b_%h want %0b_%h", n_res, cout, sum, exp[WIDTH], exp[WIDTH-1:0]); end
            if (n_res == 0) hs_cyc = cyc;
            n_res++;
         end
         tick();
         if (n_acc == 1) begin a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; end
         if (n_acc == 2) in_valid = 1'b0;
      end
      out_ready = 1'b0;
      n_cmp++; if (n_res !== 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", n_res); end
      n_cmp++; if (acc_cyc !== hs_cyc + 1) begin
         n_bad++; $display("FAIL b2b_accept_cycle got %0d want %0d", acc_cyc, hs_cyc + 1); end
   endtask

   initial begin
      test_reset();
      test_simple();
      test_ripple();
      test_backpressure();
      test_reset_mid_add();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
